// File: rtl/irq_vector_unit.sv
// Interrupt-acknowledge vector unit: on a CPU iack rising edge it acks the router,
// then drives the selected (or spurious) vector byte until iack drops or times out.
module irq_vector_unit #(
    parameter int NUM_SLOTS      = 5,
    parameter int SLOT_IDX_WIDTH = 3,
    parameter int CFG_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      irq_int_active,
    input  logic [SLOT_IDX_WIDTH-1:0] irq_int_slot,
    input  logic                      cpu_iack,
    output logic                      irq_ack,
    output logic                      vec_oe,
    output logic [7:0]                vec_data,
    input  logic                      cfg_wr_en,
    input  logic                      cfg_rd_en,
    input  logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [31:0]               cfg_wdata,
    output logic [31:0]               cfg_rdata
);
    localparam logic [CFG_ADDR_WIDTH-1:0] SPUR_ADDR    = CFG_ADDR_WIDTH'(NUM_SLOTS);
    localparam logic [CFG_ADDR_WIDTH-1:0] STATUS_ADDR  = CFG_ADDR_WIDTH'(NUM_SLOTS + 1);
    localparam logic [7:0]                TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        DRIVE    = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t      state_r;
    logic [7:0]  vector_r [NUM_SLOTS];
    logic [7:0]  spur_vec_r;
    logic [7:0]  spur_count_r;
    logic [7:0]  drive_cnt_r;
    logic        timeout_flag_r;
    logic        iack_q_r;
    logic        spur_cycle_r;

    logic        iack_rise_s;
    logic        status_clr_s;
    logic        sel_spur_s;
    logic [7:0]  sel_vec_s;
    logic [31:0] rd_data_s;
    logic        wdata_unused_s;

    assign iack_rise_s    = cpu_iack & ~iack_q_r;
    assign status_clr_s   = cfg_wr_en && (cfg_addr == STATUS_ADDR);
    assign wdata_unused_s = ^cfg_wdata[31:8];

    // Vector selection: a slot hit only when the router reports an active in-range slot.
    always_comb begin
        sel_vec_s  = spur_vec_r;
        sel_spur_s = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (irq_int_active && (irq_int_slot == SLOT_IDX_WIDTH'(i))) begin
                sel_vec_s  = vector_r[i];
                sel_spur_s = 1'b0;
            end else begin
                sel_vec_s  = sel_vec_s;
                sel_spur_s = sel_spur_s;
            end
        end
    end

    // Config read decode; unmapped addresses read zero.
    always_comb begin
        rd_data_s = 32'd0;
        if (cfg_addr == SPUR_ADDR) begin
            rd_data_s = {24'd0, spur_vec_r};
        end else if (cfg_addr == STATUS_ADDR) begin
            rd_data_s = {23'd0, timeout_flag_r, spur_count_r};
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (cfg_addr == CFG_ADDR_WIDTH'(i)) begin
                    rd_data_s = {24'd0, vector_r[i]};
                end else begin
                    rd_data_s = rd_data_s;
                end
            end
        end
    end

    // Vector configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                vector_r[i] <= 8'd0;
            end
            spur_vec_r <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (cfg_wr_en && (cfg_addr == CFG_ADDR_WIDTH'(i))) begin
                    vector_r[i] <= cfg_wdata[7:0];
                end
            end
            if (cfg_wr_en && (cfg_addr == SPUR_ADDR)) begin
                spur_vec_r <= cfg_wdata[7:0];
            end
        end
    end

    // Registered read port: data only in the cycle after a read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rdata <= 32'd0;
        end else begin
            cfg_rdata <= cfg_rd_en ? rd_data_s : 32'd0;
        end
    end

    // Acknowledge sequencer with status bookkeeping; a status clear beats any update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            irq_ack        <= 1'b0;
            vec_oe         <= 1'b0;
            vec_data       <= 8'd0;
            spur_count_r   <= 8'd0;
            timeout_flag_r <= 1'b0;
            drive_cnt_r    <= 8'd0;
            iack_q_r       <= 1'b0;
            spur_cycle_r   <= 1'b0;
        end else begin
            iack_q_r <= cpu_iack;
            irq_ack  <= 1'b0;
            case (state_r)
                IDLE: begin
                    vec_oe <= 1'b0;
                    if (iack_rise_s) begin
                        state_r      <= ACK;
                        vec_data     <= sel_vec_s;
                        spur_cycle_r <= sel_spur_s;
                        irq_ack      <= ~sel_spur_s;
                    end
                end
                ACK: begin
                    state_r     <= DRIVE;
                    vec_oe      <= 1'b1;
                    drive_cnt_r <= 8'd0;
                end
                DRIVE: begin
                    if (!cpu_iack) begin
                        state_r <= IDLE;
                        vec_oe  <= 1'b0;
                    end else if (drive_cnt_r == TIMEOUT_LAST) begin
                        state_r <= WAIT_REL;
                        vec_oe  <= 1'b0;
                    end else begin
                        drive_cnt_r <= drive_cnt_r + 8'd1;
                    end
                end
                WAIT_REL: begin
                    vec_oe <= 1'b0;
                    if (!cpu_iack) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    vec_oe  <= 1'b0;
                end
            endcase

            if (status_clr_s) begin
                spur_count_r   <= 8'd0;
                timeout_flag_r <= 1'b0;
            end else begin
                if ((state_r == ACK) && spur_cycle_r && (spur_count_r != 8'hFF)) begin
                    spur_count_r <= spur_count_r + 8'd1;
                end
                if ((state_r == DRIVE) && cpu_iack && (drive_cnt_r == TIMEOUT_LAST)) begin
                    timeout_flag_r <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_irq_vector_unit.sv
// Bench for irq_vector_unit: directed table, multi-cycle corner sequences and
// random stimulus checked against a transaction-level reference model.
module tb_irq_vector_unit;
    localparam int NS = 5;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        irq_int_active = 1'b0;
    logic [2:0]  irq_int_slot = 3'd0;
    logic        cpu_iack = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic        cfg_rd_en = 1'b0;
    logic [7:0]  cfg_addr = 8'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic        irq_ack;
    logic        vec_oe;
    logic [7:0]  vec_data;
    logic [31:0] cfg_rdata;

    always #5 clk = ~clk;

    irq_vector_unit #(
        .NUM_SLOTS(NS), .SLOT_IDX_WIDTH(3), .CFG_ADDR_WIDTH(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .irq_int_active(irq_int_active), .irq_int_slot(irq_int_slot),
        .cpu_iack(cpu_iack), .irq_ack(irq_ack), .vec_oe(vec_oe), .vec_data(vec_data),
        .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: one acknowledge transaction at a time, tracked by phase flags
    logic [7:0]  m_vec [NS] = '{default: 8'd0};
    logic [7:0]  m_spur_vec = 8'd0;
    logic [7:0]  m_count = 8'd0;
    logic        m_flag = 1'b0;
    bit          m_prev = 1'b0, m_busy = 1'b0, m_in_ack = 1'b0, m_spur = 1'b0;
    int          m_drive_n = 0;
    logic        m_ack = 1'b0, m_oe = 1'b0;
    logic [7:0]  m_data = 8'd0;
    logic [31:0] m_rdata = 32'd0;

    typedef struct {
        logic r; logic act; logic [2:0] slot; logic iack; logic wr; logic rd;
        logic [7:0] addr; logic [31:0] wd;
        logic e_ack; logic e_oe; logic [7:0] e_data; logic [31:0] e_rdata;
    } vec_t;
    vec_t tbl [25];

    function automatic logic [31:0] model_read(input logic [7:0] a);
        if (int'(a) < NS) return {24'd0, m_vec[int'(a)]};
        else if (int'(a) == NS) return {24'd0, m_spur_vec};
        else if (int'(a) == NS + 1) return {23'd0, m_flag, m_count};
        else return 32'd0;
    endfunction

    task automatic model_step();
        bit rise, clear, sel_spur;
        logic [7:0] sel;
        if (rst) begin
            for (int i = 0; i < NS; i++) m_vec[i] = 8'd0;
            m_spur_vec = 8'd0; m_count = 8'd0; m_flag = 1'b0;
            m_prev = 1'b0; m_busy = 1'b0; m_in_ack = 1'b0;
            m_ack = 1'b0; m_oe = 1'b0; m_data = 8'd0; m_rdata = 32'd0;
            return;
        end
        rise     = cpu_iack && !m_prev;
        clear    = cfg_wr_en && (int'(cfg_addr) == NS + 1);
        m_rdata  = cfg_rd_en ? model_read(cfg_addr) : 32'd0;
        sel_spur = !(irq_int_active && int'(irq_int_slot) < NS);
        sel      = m_spur_vec;
        if (!sel_spur) sel = m_vec[int'(irq_int_slot)];
        m_ack = 1'b0;
        if (!m_busy) begin
            m_oe = 1'b0;
            if (rise) begin
                m_busy = 1'b1; m_in_ack = 1'b1; m_spur = sel_spur;
                m_data = sel; m_ack = !sel_spur;
            end
        end else if (m_in_ack) begin
            m_in_ack = 1'b0; m_oe = 1'b1; m_drive_n = 1;
            if (m_spur && m_count < 8'd255) m_count = m_count + 8'd1;
        end else if (m_oe) begin
            if (!cpu_iack) begin
                m_oe = 1'b0; m_busy = 1'b0;
            end else if (m_drive_n == TO) begin
                m_oe = 1'b0; m_flag = 1'b1;
            end else begin
                m_drive_n++;
            end
        end else if (!cpu_iack) begin
            m_busy = 1'b0;
        end
        if (clear) begin
            m_count = 8'd0; m_flag = 1'b0;
        end
        if (cfg_wr_en && int'(cfg_addr) < NS) m_vec[int'(cfg_addr)] = cfg_wdata[7:0];
        else if (cfg_wr_en && int'(cfg_addr) == NS) m_spur_vec = cfg_wdata[7:0];
        m_prev = cpu_iack;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic act, input logic [2:0] slot, input logic iack,
                        input logic wr, input logic rd, input logic [7:0] addr, input logic [31:0] wd);
        rst = r; irq_int_active = act; irq_int_slot = slot; cpu_iack = iack;
        cfg_wr_en = wr; cfg_rd_en = rd; cfg_addr = addr; cfg_wdata = wd;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("model_irq_ack", 32'(irq_ack), 32'(m_ack));
        check("model_vec_oe", 32'(vec_oe), 32'(m_oe));
        check("model_vec_data", 32'(vec_data), 32'(m_data));
        check("model_cfg_rdata", cfg_rdata, m_rdata);
        @(negedge clk);
    endtask

    initial begin
        int oe_cycles;
        logic cur_iack;
        //          r     act   slot  iack  wr    rd    addr   wdata      ack   oe    data   rdata
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b0, 8'h00, 32'h000};
        tbl[1]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd2, 32'h48, 1'b0, 1'b0, 8'h00, 32'h000};
        tbl[2]  = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 32'h00, 1'b1, 1'b0, 8'h48, 32'h000};
        tbl[3]  = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b1, 8'h48, 32'h000};
        tbl[4]  = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b1, 8'h48, 32'h000};
        tbl[5]  = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 8'd2, 32'h00, 1'b0, 1'b1, 8'h48, 32'h048};
        tbl[6]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b0, 8'h48, 32'h000};
        tbl[7]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'd6, 32'h00, 1'b0, 1'b0, 8'h48, 32'h000};
        tbl[8]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd5, 32'hFF, 1'b0, 1'b0, 8'h48, 32'h000};
        tbl[9]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b0, 8'hFF, 32'h000};
        tbl[10] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b1, 8'hFF, 32'h000};
        tbl[11] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b0, 8'hFF, 32'h000};
        tbl[12] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'd6, 32'h00, 1'b0, 1'b0, 8'hFF, 32'h001};
        tbl[13] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'd7, 32'hAB, 1'b0, 1'b0, 8'hFF, 32'h000};
        tbl[14] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'd5, 32'h00, 1'b0, 1'b0, 8'hFF, 32'h0FF};
        tbl[15] = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 32'h00, 1'b1, 1'b0, 8'h48, 32'h000};
        tbl[16] = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 8'd2, 32'h10, 1'b0, 1'b1, 8'h48, 32'h000};
        tbl[17] = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b1, 8'h48, 32'h000};
        tbl[18] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b0, 8'h48, 32'h000};
        tbl[19] = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 32'h00, 1'b1, 1'b0, 8'h10, 32'h000};
        tbl[20] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b1, 8'h10, 32'h000};
        tbl[21] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b0, 8'h10, 32'h000};
        tbl[22] = '{1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b0, 8'hFF, 32'h000};
        tbl[23] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b1, 8'hFF, 32'h000};
        tbl[24] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'd6, 32'h00, 1'b0, 1'b0, 8'hFF, 32'h002};

        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            tick(tbl[i].r, tbl[i].act, tbl[i].slot, tbl[i].iack,
                 tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd);
            check($sformatf("tbl%0d_irq_ack", i), 32'(irq_ack), 32'(tbl[i].e_ack));
            check($sformatf("tbl%0d_vec_oe", i), 32'(vec_oe), 32'(tbl[i].e_oe));
            check($sformatf("tbl%0d_vec_data", i), 32'(vec_data), 32'(tbl[i].e_data));
            check($sformatf("tbl%0d_cfg_rdata", i), cfg_rdata, tbl[i].e_rdata);
        end

        // Timeout: iack held 20 cycles gives exactly TO drive cycles and a sticky flag
        tick(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd1, 32'h5A);
        oe_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
            if (vec_oe) oe_cycles++;
        end
        check("timeout_oe_cycles", 32'(oe_cycles), 32'(TO));
        tick(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 8'd6, 32'd0);
        check("timeout_status", cfg_rdata, 32'h100);
        check("timeout_wait_oe", 32'(vec_oe), 32'd0);
        tick(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        tick(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
        check("timeout_reack", 32'(irq_ack), 32'd1);
        check("timeout_reack_data", 32'(vec_data), 32'h5A);
        tick(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        tick(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);

        // Spurious count saturation, then a clear racing a spurious ACK
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd6, 32'd0);
        for (int i = 0; i < 256; i++) begin
            tick(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
            tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
            tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        end
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'd6, 32'd0);
        check("sat_count", cfg_rdata, 32'h0FF);
        tick(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd6, 32'hFFFF_FFFF);
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'd6, 32'd0);
        check("clear_wins", cfg_rdata, 32'h000);

        // Reset mid-DRIVE aborts the cycle; held iack re-triggers after reset
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd3, 32'h77);
        tick(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
        tick(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
        check("pre_rst_oe", 32'(vec_oe), 32'd1);
        check("pre_rst_data", 32'(vec_data), 32'h77);
        tick(1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
        check("rst_oe", 32'(vec_oe), 32'd0);
        check("rst_data", 32'(vec_data), 32'd0);
        tick(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
        check("post_rst_ack", 32'(irq_ack), 32'd1);
        tick(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        tick(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        for (int a = 0; a <= NS + 1; a++) begin
            tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'(a), 32'd0);
            check($sformatf("rst_cfg%0d", a), cfg_rdata, 32'd0);
        end

        // Random traffic against the model
        cur_iack = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 15) cur_iack = ~cur_iack;
            tick(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), cur_iack,
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 9)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
